// File: rtl/keypad_time_entry_if.sv
// Keypad-to-timer bus: key inputs from the scanner side, digit/load/stop outputs
// toward the timer digit counters.
interface keypad_time_entry_if;
  logic       key_pressed;
  logic [3:0] key_code;
  logic       timer_busy;
  logic       load;
  logic       stop_req;
  logic [3:0] bcd_min;
  logic [3:0] bcd_sec_tens;
  logic [3:0] bcd_sec_ones;
  logic [1:0] digit_count;
  logic       error;

  modport master (
    output key_pressed, key_code, timer_busy,
    input  load, stop_req, bcd_min, bcd_sec_tens, bcd_sec_ones, digit_count, error
  );

  modport slave (
    input  key_pressed, key_code, timer_busy,
    output load, stop_req, bcd_min, bcd_sec_tens, bcd_sec_ones, digit_count, error
  );
endinterface

// File: rtl/keypad_time_entry.sv
// Microwave-style 3-digit time entry: shift-in digits, START validates and
// pulses load to the digit counters, CANCEL clears or requests a timer stop.
module keypad_time_entry #(
  parameter int unsigned MAX_SEC_TENS = 5,
  parameter int unsigned ERR_CYCLES   = 8
) (
  input  logic                 clk,
  input  logic                 clear,
  keypad_time_entry_if.slave   bus
);

  localparam int unsigned    ERR_W    = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_CYCLES - 1);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [3:0] KEY_START     = 4'd10;
  localparam logic [3:0] KEY_CANCEL    = 4'd11;

  // A time of 0:00 or a seconds-tens digit beyond the limit cannot be loaded.
  function automatic logic entry_valid(input logic [3:0] min_d,
                                       input logic [3:0] tens_d,
                                       input logic [3:0] ones_d);
    return (tens_d <= 4'(MAX_SEC_TENS)) && ({min_d, tens_d, ones_d} != 12'd0);
  endfunction

  logic [1:0]       state_r,   state_s;
  logic [3:0]       min_r,     min_s;
  logic [3:0]       tens_r,    tens_s;
  logic [3:0]       ones_r,    ones_s;
  logic [1:0]       count_r,   count_s;
  logic             load_r,    load_s;
  logic             stop_r,    stop_s;
  logic             error_r,   error_s;
  logic [ERR_W-1:0] err_cnt_r, err_cnt_s;
  logic             key_prev_r;

  logic key_event_s;
  logic digit_evt_s;
  logic start_evt_s;
  logic cancel_evt_s;

  assign key_event_s  = bus.key_pressed & ~key_prev_r;
  assign digit_evt_s  = key_event_s & (bus.key_code <= KEY_MAX_DIGIT);
  assign start_evt_s  = key_event_s & (bus.key_code == KEY_START);
  assign cancel_evt_s = key_event_s & (bus.key_code == KEY_CANCEL);

  // Next-state and next-output computation for the entry FSM.
  always_comb begin
    state_s   = state_r;
    min_s     = min_r;
    tens_s    = tens_r;
    ones_s    = ones_r;
    count_s   = count_r;
    load_s    = 1'b0;
    stop_s    = 1'b0;
    error_s   = error_r;
    err_cnt_s = err_cnt_r;
    case (state_r)
      ST_EMPTY, ST_ENTRY: begin
        if (cancel_evt_s) begin
          if (bus.timer_busy) begin
            stop_s = 1'b1;
          end else begin
            min_s   = 4'd0;
            tens_s  = 4'd0;
            ones_s  = 4'd0;
            count_s = 2'd0;
            error_s = 1'b0;
            state_s = ST_EMPTY;
          end
        end else if (digit_evt_s && !bus.timer_busy) begin
          // A full buffer freezes; extra digits are dropped, not shifted.
          if (count_r != 2'd3) begin
            min_s   = tens_r;
            tens_s  = ones_r;
            ones_s  = bus.key_code;
            count_s = count_r + 2'd1;
            state_s = ST_ENTRY;
          end else begin
            state_s = ST_ENTRY;
          end
        end else if (start_evt_s && !bus.timer_busy && (state_r == ST_ENTRY)) begin
          if (entry_valid(min_r, tens_r, ones_r)) begin
            load_s  = 1'b1;
            state_s = ST_LOAD;
          end else begin
            min_s     = 4'd0;
            tens_s    = 4'd0;
            ones_s    = 4'd0;
            count_s   = 2'd0;
            error_s   = 1'b1;
            err_cnt_s = '0;
            state_s   = ST_ERROR;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        // Digits stay on the bus after the load so the display keeps them.
        state_s = ST_EMPTY;
        count_s = 2'd0;
        if (cancel_evt_s) begin
          if (bus.timer_busy) begin
            stop_s = 1'b1;
          end else begin
            min_s  = 4'd0;
            tens_s = 4'd0;
            ones_s = 4'd0;
          end
        end else begin
          stop_s = 1'b0;
        end
      end
      ST_ERROR: begin
        if (cancel_evt_s && !bus.timer_busy) begin
          error_s   = 1'b0;
          err_cnt_s = '0;
          state_s   = ST_EMPTY;
        end else begin
          stop_s = cancel_evt_s;
          if (err_cnt_r == ERR_LAST) begin
            error_s   = 1'b0;
            err_cnt_s = '0;
            state_s   = ST_EMPTY;
          end else begin
            err_cnt_s = err_cnt_r + 1'b1;
          end
        end
      end
      default: begin
        state_s = ST_EMPTY;
        count_s = 2'd0;
        error_s = 1'b0;
      end
    endcase
  end

  // State, digit buffer and registered outputs; clear wins over everything.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r    <= ST_EMPTY;
      min_r      <= 4'd0;
      tens_r     <= 4'd0;
      ones_r     <= 4'd0;
      count_r    <= 2'd0;
      load_r     <= 1'b0;
      stop_r     <= 1'b0;
      error_r    <= 1'b0;
      err_cnt_r  <= '0;
      key_prev_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      min_r      <= min_s;
      tens_r     <= tens_s;
      ones_r     <= ones_s;
      count_r    <= count_s;
      load_r     <= load_s;
      stop_r     <= stop_s;
      error_r    <= error_s;
      err_cnt_r  <= err_cnt_s;
      key_prev_r <= bus.key_pressed;
    end
  end

  assign bus.load         = load_r;
  assign bus.stop_req     = stop_r;
  assign bus.bcd_min      = min_r;
  assign bus.bcd_sec_tens = tens_r;
  assign bus.bcd_sec_ones = ones_r;
  assign bus.digit_count  = count_r;
  assign bus.error        = error_r;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed test-plan steps followed by random key traffic, every cycle checked
// against a time-value reference model.
module tb_keypad_time_entry;

  logic clk = 1'b0;
  logic clear;

  always #5 clk = ~clk;

  keypad_time_entry_if bus_if();

  keypad_time_entry #(.MAX_SEC_TENS(5), .ERR_CYCLES(8)) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus_if)
  );

  int checks = 0;
  int failures = 0;
  int load_seen = 0;
  int stop_seen = 0;
  int err_seen = 0;

  // Model: the buffer is the 3-digit number m_t; m_err counts remaining error cycles.
  int m_t = 0;
  int m_cnt = 0;
  int m_err = 0;
  bit m_load = 1'b0;
  bit m_stop = 1'b0;
  bit m_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit ev;
    int code;
    bit busy;
    if (clear) begin
      m_t = 0; m_cnt = 0; m_err = 0; m_load = 1'b0; m_stop = 1'b0; m_prev = 1'b0;
      return;
    end
    ev     = bus_if.key_pressed && !m_prev;
    m_prev = bus_if.key_pressed;
    code   = int'(bus_if.key_code);
    busy   = bus_if.timer_busy;
    m_stop = 1'b0;
    if (m_err > 0) begin
      if (ev && code == 11 && !busy) begin
        m_err = 0; m_t = 0; m_cnt = 0;
      end else begin
        if (ev && code == 11) m_stop = 1'b1;
        m_err--;
      end
    end else if (m_load) begin
      m_load = 1'b0;
      m_cnt  = 0;
      if (ev && code == 11) begin
        if (busy) m_stop = 1'b1;
        else m_t = 0;
      end
    end else if (ev) begin
      if (code <= 9) begin
        if (!busy && m_cnt < 3) begin
          m_t = (m_t % 100) * 10 + code;
          m_cnt++;
        end
      end else if (code == 10) begin
        if (!busy && m_cnt > 0) begin
          if (((m_t / 10) % 10) > 5 || m_t == 0) begin
            m_err = 8; m_t = 0; m_cnt = 0;
          end else begin
            m_load = 1'b1;
          end
        end
      end else if (code == 11) begin
        if (busy) m_stop = 1'b1;
        else begin m_t = 0; m_cnt = 0; end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (bus_if.load === 1'b1) load_seen++;
    if (bus_if.stop_req === 1'b1) stop_seen++;
    if (bus_if.error === 1'b1) err_seen++;
    check("load",         32'(bus_if.load),         32'(m_load));
    check("stop_req",     32'(bus_if.stop_req),     32'(m_stop));
    check("error",        32'(bus_if.error),        32'(m_err > 0));
    check("digit_count",  32'(bus_if.digit_count),  32'(m_cnt));
    check("bcd_min",      32'(bus_if.bcd_min),      32'(m_t / 100));
    check("bcd_sec_tens", 32'(bus_if.bcd_sec_tens), 32'((m_t / 10) % 10));
    check("bcd_sec_ones", 32'(bus_if.bcd_sec_ones), 32'(m_t % 10));
    check("load_stop_excl", 32'(bus_if.load & bus_if.stop_req), 32'd0);
  endtask

  task automatic press(input int code);
    bus_if.key_pressed = 1'b1;
    bus_if.key_code    = 4'(code);
    cycle();
    bus_if.key_pressed = 1'b0;
    cycle();
  endtask

  task automatic check_digits(input string tag, input int mn, input int tn, input int on, input int cnt);
    check({tag, "_min"},  32'(bus_if.bcd_min),      32'(mn));
    check({tag, "_tens"}, 32'(bus_if.bcd_sec_tens), 32'(tn));
    check({tag, "_ones"}, 32'(bus_if.bcd_sec_ones), 32'(on));
    check({tag, "_cnt"},  32'(bus_if.digit_count),  32'(cnt));
  endtask

  initial begin
    int saved_min, saved_tens, saved_ones;
    clear              = 1'b1;
    bus_if.key_pressed = 1'b0;
    bus_if.key_code    = 4'd0;
    bus_if.timer_busy  = 1'b0;
    cycle();
    cycle();
    clear = 1'b0;
    check_digits("reset", 0, 0, 0, 0);
    check("reset_load",  32'(bus_if.load),     32'd0);
    check("reset_stop",  32'(bus_if.stop_req), 32'd0);
    check("reset_error", 32'(bus_if.error),    32'd0);

    // Plan 1: 1,3,0 then START
    press(1); press(3); press(0);
    check_digits("p1_entry", 1, 3, 0, 3);
    load_seen = 0;
    press(10);
    cycle(); cycle();
    check("p1_load_count", 32'(load_seen), 32'd1);
    check_digits("p1_after", 1, 3, 0, 0);

    // Plan 2: hold 7 for 20 cycles
    bus_if.key_pressed = 1'b1;
    bus_if.key_code    = 4'd7;
    repeat (20) cycle();
    bus_if.key_pressed = 1'b0;
    cycle();
    check("p2_ones", 32'(bus_if.bcd_sec_ones), 32'd7);
    check("p2_cnt",  32'(bus_if.digit_count),  32'd1);
    press(11);
    check_digits("p2_cancel", 0, 0, 0, 0);

    // Plan 3: 9,9,9,5 then START -> error
    press(9); press(9); press(9); press(5);
    check_digits("p3_full", 9, 9, 9, 3);
    load_seen = 0;
    err_seen  = 0;
    press(10);
    repeat (10) cycle();
    check("p3_err_cycles", 32'(err_seen),  32'd8);
    check("p3_no_load",    32'(load_seen), 32'd0);
    check("p3_err_end",    32'(bus_if.error), 32'd0);
    check_digits("p3_cleared", 0, 0, 0, 0);

    // Plan 4: 0 then START -> error, CANCEL clears at once
    load_seen = 0;
    press(0);
    press(10);
    check("p4_error", 32'(bus_if.error), 32'd1);
    bus_if.key_pressed = 1'b1;
    bus_if.key_code    = 4'd11;
    cycle();
    check("p4_cancel_error", 32'(bus_if.error), 32'd0);
    bus_if.key_pressed = 1'b0;
    cycle();
    check("p4_no_load", 32'(load_seen), 32'd0);

    // Plan 5: busy timer ignores digits/START, CANCEL requests stop
    press(4); press(2);
    saved_min  = int'(bus_if.bcd_min);
    saved_tens = int'(bus_if.bcd_sec_tens);
    saved_ones = int'(bus_if.bcd_sec_ones);
    bus_if.timer_busy = 1'b1;
    load_seen = 0;
    stop_seen = 0;
    press(4); press(10); press(11);
    bus_if.timer_busy = 1'b0;
    check_digits("p5_kept", 0, 4, 2, 2);
    check("p5_saved_min",  32'(bus_if.bcd_min),      32'(saved_min));
    check("p5_saved_ones", 32'(bus_if.bcd_sec_ones), 32'(saved_ones + saved_tens - 4));
    check("p5_no_load",    32'(load_seen), 32'd0);
    check("p5_stop_count", 32'(stop_seen), 32'd1);

    // Plan 6: clear coincides with a START event
    press(11);
    press(2); press(5);
    load_seen          = 0;
    bus_if.key_pressed = 1'b1;
    bus_if.key_code    = 4'd10;
    clear              = 1'b1;
    cycle();
    clear              = 1'b0;
    bus_if.key_pressed = 1'b0;
    check_digits("p6_clear", 0, 0, 0, 0);
    cycle(); cycle();
    check("p6_no_load", 32'(load_seen), 32'd0);
    check("p6_error",   32'(bus_if.error), 32'd0);

    // Random traffic against the model
    repeat (1500) begin
      clear = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) bus_if.timer_busy = ~bus_if.timer_busy;
      if ($urandom_range(0, 2) == 0) begin
        bus_if.key_pressed = ~bus_if.key_pressed;
        if (bus_if.key_pressed) begin
          if ($urandom_range(0, 3) == 0) bus_if.key_code = 4'($urandom_range(10, 15));
          else bus_if.key_code = 4'($urandom_range(0, 9));
        end
      end
      cycle();
    end
    clear = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
